ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Registered execute-to-memory boundary placed directly downstream of the combinational ALU.
- Captures the ALU result, flags and instruction control bits, and detects signed-add/sub overflow from the operands.
- Suppresses writes for trapping instructions.
- Decouples EX from MEM with a valid/ready handshake and a 2-entry skid buffer.
- Exposes a bypass port so the upstream operand-select logic can forward the held result.

Parameters:
- DW, 32, datapath width of operands and result.
- CNTW, 8, width of the saturating overflow-exception counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  EX presents a valid instruction
- in_ready  output  1  stage can accept; equals NOT skid_valid (registered state only, no combinational path from out_ready)
- in_a  input  DW  ALU operand a
- in_b  input  DW  ALU operand b
- in_r  input  DW  ALU result
- in_zero  input  1  ALU zero flag
- in_carry  input  1  ALU carry flag
- in_neg  input  1  ALU negative flag
- in_aluc  input  4  ALU opcode
- in_rd  input  5  destination register
- in_reg_we  input  1  register write enable
- in_mem_we  input  1  store
- in_mem_re  input  1  load
- in_sdata  input  DW  store data
- flush  input  1  synchronous kill of all held entries
- out_valid  output  1  output entry valid
- out_ready  input  1  MEM consumes when out_valid
- out_r  output  DW  result
- out_zero, out_carry, out_neg  output  1 each  latched flags
- out_rd  output  5  destination register
- out_reg_we, out_mem_we, out_mem_re  output  1 each  write/read enables, already gated by exception
- out_sdata  output  DW  store data
- out_exc  output  1  entry raised an overflow exception
- fwd_valid  output  1  out_valid & out_reg_we & (out_rd != 0)
- fwd_rd  output  5  equals out_rd
- fwd_data  output  DW  equals out_r
- exc_count  output  CNTW  saturating count of accepted exception entries

Behaviour:
- Reset (async, rst=1):
  - main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1.
  - All data/control outputs are 0; exc_count=0; fwd_valid=0.
- Overflow detect, combinational on inputs:
  - aluc=0010: ovf = (a[31]==b[31]) & (r[31]!=a[31]).
  - aluc=0011: ovf = (a[31]!=b[31]) & (r[31]!=a[31]).
  - Any other aluc: ovf=0.
- Exception gating: when ovf=1 the captured entry has exc=1 and reg_we=mem_we=mem_re=0. Result and flags are still captured unchanged.
- Transfer terms: accept = in_valid & in_ready & ~flush; consume = out_valid & out_ready.
- Latency: an accepted entry appears on outputs the next cycle when main is empty or consumed that cycle.
- Main/skid state per rising edge (flush=0):
  - Main empty, or consume: main loads skid if skid_valid (skid cleared), else loads the accepted entry, else main_valid=0.
  - If skid moved to main and accept also occurs, the accepted entry goes to skid.
  - Main full and no consume: an accepted entry goes to skid (skid_valid=1, in_ready drops next cycle).
  - Both full, no consume: hold; in_ready=0 so no accept is possible.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Flush=1:
  - Next edge main_valid=skid_valid=0, in_ready=1.
  - Input that cycle is discarded, even if in_valid=1.
  - The consume handshake that cycle still counts at MEM; the stage just clears.
- exc_count:
  - Increments by 1 on an accept with ovf=1.
  - Saturates at 2^CNTW-1.
  - Not affected by flush; cleared only by rst.
- Reset mid-operation: immediate clear regardless of clk.
- Data registers hold their last value when a valid bit is 0 (only valid bits matter).

Test Plan:
1. Reset with in_valid=1 → out_valid=0, in_ready=1, exc_count=0. Release, present addu 5+7 (aluc=0000, r=12, rd=3, reg_we=1), out_ready=1 → next cycle out_valid=1, out_r=12, fwd_valid=1, fwd_rd=3, fwd_data=12.
2. Signed add a=0x7FFFFFFF, b=1, aluc=0010, r=0x80000000, reg_we=1 → out_exc=1, out_reg_we=0, out_r=0x80000000, exc_count=1. Sub a=0x80000000, b=1, aluc=0011, r=0x7FFFFFFF → out_exc=1, exc_count=2. Same a/b with aluc=0001 → out_exc=0.
3. out_ready=0, stream results 1, 2, 3 every cycle → 1 in main, 2 in skid, in_ready=0 from cycle 3 (3 held upstream). Raise out_ready → MEM receives 1, 2, 3 in order, one per cycle; in_ready returns to 1.
4. Main+skid full, assert flush with in_valid=1 (r=9) → next cycle out_valid=0, in_ready=1, value 9 never appears at output.
5. Write to rd=0 with reg_we=1 → out_valid=1, fwd_valid=0.
6. CNTW=2: five overflow instructions → exc_count 1, 2, 3, 3, 3. Assert rst asynchronously mid-stream (between clock edges) → all valids and exc_count drop to 0 immediately.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// Execute-to-memory boundary bus: upstream EX handshake, downstream MEM handshake,
// forwarding port and exception counter, with a view for each side.
interface ex_mem_stage_if #(
  parameter int DW   = 32,
  parameter int CNTW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic [DW-1:0]   in_r;
  logic            in_zero;
  logic            in_carry;
  logic            in_neg;
  logic [3:0]      in_aluc;
  logic [4:0]      in_rd;
  logic            in_reg_we;
  logic            in_mem_we;
  logic            in_mem_re;
  logic [DW-1:0]   in_sdata;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_r;
  logic            out_zero;
  logic            out_carry;
  logic            out_neg;
  logic [4:0]      out_rd;
  logic            out_reg_we;
  logic            out_mem_we;
  logic            out_mem_re;
  logic [DW-1:0]   out_sdata;
  logic            out_exc;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [DW-1:0]   fwd_data;
  logic [CNTW-1:0] exc_count;

  modport master (
    output in_valid, in_a, in_b, in_r, in_zero, in_carry, in_neg, in_aluc, in_rd,
           in_reg_we, in_mem_we, in_mem_re, in_sdata, flush, out_ready,
    input  in_ready, out_valid, out_r, out_zero, out_carry, out_neg, out_rd,
           out_reg_we, out_mem_we, out_mem_re, out_sdata, out_exc,
           fwd_valid, fwd_rd, fwd_data, exc_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_r, in_zero, in_carry, in_neg, in_aluc, in_rd,
           in_reg_we, in_mem_we, in_mem_re, in_sdata, flush, out_ready,
    output in_ready, out_valid, out_r, out_zero, out_carry, out_neg, out_rd,
           out_reg_we, out_mem_we, out_mem_re, out_sdata, out_exc,
           fwd_valid, fwd_rd, fwd_data, exc_count
  );
endinterface

// File: rtl/ex_mem_stage.sv
// Registered EX->MEM boundary: overflow trap gating, 2-entry skid buffer with
// valid/ready on both sides, result forwarding and a saturating exception counter.
module ex_mem_stage #(
  parameter int DW   = 32,
  parameter int CNTW = 8
) (
  input logic           clk,
  input logic           rst,
  ex_mem_stage_if.slave bus
);

  typedef struct packed {
    logic [DW-1:0] r;
    logic          zero;
    logic          carry;
    logic          neg;
    logic [4:0]    rd;
    logic          reg_we;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] sdata;
    logic          exc;
  } entry_t;

  // Signed overflow of add (0010) and sub (0011), judged from operand/result sign bits.
  function automatic logic ovf_detect(input logic [3:0] aluc, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    logic ovf;
    case (aluc)
      4'b0010: ovf = (a_msb == b_msb) & (r_msb != a_msb);
      4'b0011: ovf = (a_msb != b_msb) & (r_msb != a_msb);
      default: ovf = 1'b0;
    endcase
    return ovf;
  endfunction

  entry_t          main_q, skid_q, main_d, skid_d, in_entry;
  logic            main_valid, skid_valid, main_valid_d, skid_valid_d;
  logic            fwd_valid_q, fwd_valid_d;
  logic [CNTW-1:0] exc_count_q;
  logic            ovf, accept, consume;

  assign ovf     = ovf_detect(bus.in_aluc, bus.in_a[DW-1], bus.in_b[DW-1], bus.in_r[DW-1]);
  assign accept  = bus.in_valid & ~skid_valid & ~bus.flush;
  assign consume = main_valid & bus.out_ready;

  // Build the incoming entry; a trapping instruction keeps its result but loses all enables.
  always_comb begin
    in_entry.r      = bus.in_r;
    in_entry.zero   = bus.in_zero;
    in_entry.carry  = bus.in_carry;
    in_entry.neg    = bus.in_neg;
    in_entry.rd     = bus.in_rd;
    in_entry.sdata  = bus.in_sdata;
    in_entry.exc    = ovf;
    if (ovf) begin
      in_entry.reg_we = 1'b0;
      in_entry.mem_we = 1'b0;
      in_entry.mem_re = 1'b0;
    end else begin
      in_entry.reg_we = bus.in_reg_we;
      in_entry.mem_we = bus.in_mem_we;
      in_entry.mem_re = bus.in_mem_re;
    end
  end

  // Main/skid next state; accept only happens with skid empty, so skid never refills while draining.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid || consume) begin
      if (skid_valid) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end else begin
      skid_valid_d = skid_valid;
    end
    fwd_valid_d = main_valid_d & main_d.reg_we & (main_d.rd != 5'd0);
  end

  // State registers and the saturating exception counter (untouched by flush).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q      <= '0;
      skid_q      <= '0;
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      fwd_valid_q <= 1'b0;
      exc_count_q <= {CNTW{1'b0}};
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      main_valid  <= main_valid_d;
      skid_valid  <= skid_valid_d;
      fwd_valid_q <= fwd_valid_d;
      if (accept && ovf && (exc_count_q != {CNTW{1'b1}})) begin
        exc_count_q <= exc_count_q + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.in_ready   = ~skid_valid;
  assign bus.out_valid  = main_valid;
  assign bus.out_r      = main_q.r;
  assign bus.out_zero   = main_q.zero;
  assign bus.out_carry  = main_q.carry;
  assign bus.out_neg    = main_q.neg;
  assign bus.out_rd     = main_q.rd;
  assign bus.out_reg_we = main_q.reg_we;
  assign bus.out_mem_we = main_q.mem_we;
  assign bus.out_mem_re = main_q.mem_re;
  assign bus.out_sdata  = main_q.sdata;
  assign bus.out_exc    = main_q.exc;
  assign bus.fwd_valid  = fwd_valid_q;
  assign bus.fwd_rd     = main_q.rd;
  assign bus.fwd_data   = main_q.r;
  assign bus.exc_count  = exc_count_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: one default-width instance and one with a
// 2-bit exception counter for the saturation and async-reset checks.
module tb_ex_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ex_mem_stage_if #(.DW(32), .CNTW(8)) b8 ();
  ex_mem_stage_if #(.DW(32), .CNTW(2)) b2 ();

  ex_mem_stage #(.DW(32), .CNTW(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  ex_mem_stage #(.DW(32), .CNTW(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] aluc, input logic [4:0] rd,
                        input logic reg_we, input logic mem_we);
    b8.in_valid  = v;
    b8.in_a      = a;
    b8.in_b      = b;
    b8.in_r      = r;
    b8.in_aluc   = aluc;
    b8.in_rd     = rd;
    b8.in_reg_we = reg_we;
    b8.in_mem_we = mem_we;
    b8.in_zero   = (r == 32'd0);
    b8.in_neg    = r[31];
  endtask

  initial begin
    b8.in_carry = 1'b0; b8.in_mem_re = 1'b0; b8.in_sdata = 32'h0000_00AA;
    b8.flush = 1'b0; b8.out_ready = 1'b0;
    drive8(1'b1, 32'd5, 32'd7, 32'd12, 4'b0000, 5'd3, 1'b1, 1'b0);
    b2.in_valid = 1'b0; b2.in_a = 32'h7FFF_FFFF; b2.in_b = 32'd1; b2.in_r = 32'h8000_0000;
    b2.in_zero = 1'b0; b2.in_carry = 1'b0; b2.in_neg = 1'b1; b2.in_aluc = 4'b0010;
    b2.in_rd = 5'd1; b2.in_reg_we = 1'b1; b2.in_mem_we = 1'b0; b2.in_mem_re = 1'b0;
    b2.in_sdata = 32'd0; b2.flush = 1'b0; b2.out_ready = 1'b1;

    // 1: reset held with in_valid high, then a plain addu
    step();
    check_eq("rst_out_valid", b8.out_valid, 1'b0);
    check_eq("rst_in_ready", b8.in_ready, 1'b1);
    check_eq("rst_exc_count", b8.exc_count, 8'd0);
    check_eq("rst_out_r", b8.out_r, 32'd0);
    check_eq("rst_fwd_valid", b8.fwd_valid, 1'b0);
    rst = 1'b0;
    b8.out_ready = 1'b1;
    step();
    check_eq("addu_valid", b8.out_valid, 1'b1);
    check_eq("addu_r", b8.out_r, 32'd12);
    check_eq("addu_fwd_valid", b8.fwd_valid, 1'b1);
    check_eq("addu_fwd_rd", b8.fwd_rd, 5'd3);
    check_eq("addu_fwd_data", b8.fwd_data, 32'd12);
    check_eq("addu_exc", b8.out_exc, 1'b0);

    // 2: overflow detection and write suppression
    drive8(1'b1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0010, 5'd4, 1'b1, 1'b0);
    step();
    check_eq("add_ovf_exc", b8.out_exc, 1'b1);
    check_eq("add_ovf_reg_we", b8.out_reg_we, 1'b0);
    check_eq("add_ovf_r", b8.out_r, 32'h8000_0000);
    check_eq("add_ovf_neg", b8.out_neg, 1'b1);
    check_eq("add_ovf_cnt", b8.exc_count, 8'd1);
    check_eq("add_ovf_fwd", b8.fwd_valid, 1'b0);
    drive8(1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0011, 5'd4, 1'b1, 1'b0);
    step();
    check_eq("sub_ovf_exc", b8.out_exc, 1'b1);
    check_eq("sub_ovf_cnt", b8.exc_count, 8'd2);
    drive8(1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0001, 5'd4, 1'b1, 1'b0);
    step();
    check_eq("aluc1_exc", b8.out_exc, 1'b0);
    check_eq("aluc1_reg_we", b8.out_reg_we, 1'b1);
    check_eq("aluc1_cnt", b8.exc_count, 8'd2);
    drive8(1'b1, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0010, 5'd0, 1'b0, 1'b1);
    step();
    check_eq("store_ovf_mem_we", b8.out_mem_we, 1'b0);
    check_eq("store_ovf_cnt", b8.exc_count, 8'd3);
    drive8(1'b1, 32'd5, 32'd3, 32'd2, 4'b0011, 5'd6, 1'b1, 1'b1);
    step();
    check_eq("sub_ok_exc", b8.out_exc, 1'b0);
    check_eq("sub_ok_mem_we", b8.out_mem_we, 1'b1);
    drive8(1'b0, 32'd0, 32'd0, 32'd0, 4'b0000, 5'd0, 1'b0, 1'b0);
    step();
    check_eq("drain_valid", b8.out_valid, 1'b0);

    // 3: back-pressure fills main then skid, then drains in order
    b8.out_ready = 1'b0;
    drive8(1'b1, 32'd0, 32'd0, 32'd1, 4'b0000, 5'd7, 1'b1, 1'b0);
    step();
    check_eq("bp1_r", b8.out_r, 32'd1);
    check_eq("bp1_in_ready", b8.in_ready, 1'b1);
    drive8(1'b1, 32'd0, 32'd0, 32'd2, 4'b0000, 5'd7, 1'b1, 1'b0);
    step();
    check_eq("bp2_in_ready", b8.in_ready, 1'b0);
    drive8(1'b1, 32'd0, 32'd0, 32'd3, 4'b0000, 5'd7, 1'b1, 1'b0);
    step();
    check_eq("bp3_r_held", b8.out_r, 32'd1);
    check_eq("bp3_in_ready", b8.in_ready, 1'b0);
    b8.out_ready = 1'b1;
    step();
    check_eq("drain2_r", b8.out_r, 32'd2);
    check_eq("drain2_in_ready", b8.in_ready, 1'b1);
    step();
    check_eq("drain3_r", b8.out_r, 32'd3);
    check_eq("drain3_valid", b8.out_valid, 1'b1);
    b8.in_valid = 1'b0;
    step();
    check_eq("drained_valid", b8.out_valid, 1'b0);

    // 4: flush with both entries full discards the flush-cycle input too
    b8.out_ready = 1'b0;
    drive8(1'b1, 32'd0, 32'd0, 32'd5, 4'b0000, 5'd8, 1'b1, 1'b0);
    step();
    drive8(1'b1, 32'd0, 32'd0, 32'd6, 4'b0000, 5'd8, 1'b1, 1'b0);
    step();
    check_eq("full_in_ready", b8.in_ready, 1'b0);
    b8.flush = 1'b1;
    drive8(1'b1, 32'h7FFF_FFFF, 32'd1, 32'd9, 4'b0010, 5'd8, 1'b1, 1'b0);
    step();
    check_eq("flush_valid", b8.out_valid, 1'b0);
    check_eq("flush_in_ready", b8.in_ready, 1'b1);
    b8.flush = 1'b0;
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b1;
    step();
    check_eq("post_flush_valid", b8.out_valid, 1'b0);
    check_eq("flush_keeps_cnt", b8.exc_count, 8'd3);

    // 5: rd=0 never forwards
    drive8(1'b1, 32'd0, 32'd0, 32'h55, 4'b0000, 5'd0, 1'b1, 1'b0);
    step();
    check_eq("rd0_valid", b8.out_valid, 1'b1);
    check_eq("rd0_fwd_valid", b8.fwd_valid, 1'b0);
    b8.in_valid = 1'b0;
    step();

    // 6: 2-bit counter saturates, then async reset mid-cycle
    b2.in_valid = 1'b1;
    step(); check_eq("sat_cnt1", b2.exc_count, 2'd1);
    step(); check_eq("sat_cnt2", b2.exc_count, 2'd2);
    step(); check_eq("sat_cnt3", b2.exc_count, 2'd3);
    step(); check_eq("sat_cnt4", b2.exc_count, 2'd3);
    step(); check_eq("sat_cnt5", b2.exc_count, 2'd3);
    check_eq("pre_rst_valid", b2.out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", b2.out_valid, 1'b0);
    check_eq("async_rst_cnt", b2.exc_count, 2'd0);
    check_eq("async_rst_in_ready", b2.in_ready, 1'b1);
    check_eq("async_rst_cnt8", b8.exc_count, 8'd0);
    b2.in_valid = 1'b0;
    step();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
